// File: rtl/vote_controller.sv
// Vote controller: counts single-candidate vote pulses into saturating
// per-candidate tallies, rejects simultaneous or saturating votes, enforces a
// post-vote lockout window and shows a selected tally on the LEDs in result
// mode.
module vote_controller #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CAND-1:0]         vote_in,
  input  logic                        mode,
  input  logic [$clog2(NUM_CAND)-1:0] cand_sel,
  output logic                        vote_ack,
  output logic                        vote_err,
  output logic                        busy,
  output logic [CNT_W-1:0]            leds
);

  localparam int SEL_W  = $clog2(NUM_CAND);
  localparam int LCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  // Lockout counter counts down from LOCK_CYCLES-1 to 0, one value per clock.
  localparam logic [LCNT_W-1:0] LOCK_LOAD = LCNT_W'(LOCK_CYCLES - 1);
  // Candidate count widened by one bit so out-of-range selects are detectable.
  localparam logic [SEL_W:0]    NUM_SEL   = (SEL_W + 1)'(NUM_CAND);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCEPT  = 2'd1,
    LOCKOUT = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t              state;
  logic [SEL_W-1:0]    cand;
  logic [LCNT_W-1:0]   lock_cnt;
  logic [CNT_W-1:0]    tally [NUM_CAND];

  logic [SEL_W-1:0]    vote_idx;
  logic                vote_single;
  logic                vote_multi;
  logic [CNT_W-1:0]    vote_tally;
  logic                sel_in_range;
  logic [CNT_W-1:0]    sel_tally;

  // Encode the pressed button and classify the vote pattern.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    vote_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_in[i]) vote_idx = SEL_W'(i);
    end
    vote_single  = $onehot(vote_in);
    vote_multi   = (vote_in != '0) && !vote_single;
    vote_tally   = tally[vote_idx];
    sel_in_range = ({1'b0, cand_sel} < NUM_SEL);
    sel_tally    = sel_in_range ? tally[cand_sel] : '0;
  end

  // Control FSM, tallies and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cand     <= '0;
      lock_cnt <= '0;
      vote_ack <= 1'b0;
      vote_err <= 1'b0;
      busy     <= 1'b0;
      leds     <= '0;
      // NOTE: the tally array is cleared by reset on purpose -- votes must
      // start from zero -- so it is built from flops, not an inferred RAM.
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else begin
      vote_ack <= 1'b0;
      vote_err <= 1'b0;
      leds     <= '0;
      case (state)
        IDLE: begin
          if (mode) begin
            state <= RESULT;
            leds  <= sel_tally;
          end else if (vote_single) begin
            // Saturation is decided here so ack/err line up with ACCEPT.
            state <= ACCEPT;
            cand  <= vote_idx;
            busy  <= 1'b1;
            if (&vote_tally) vote_err <= 1'b1;
            else             vote_ack <= 1'b1;
          end else if (vote_multi) begin
            state    <= LOCKOUT;
            lock_cnt <= LOCK_LOAD;
            busy     <= 1'b1;
            vote_err <= 1'b1;
          end
        end
        ACCEPT: begin
          // vote_ack high means the tally was below saturation.
          if (vote_ack) tally[cand] <= tally[cand] + 1'b1;
          state    <= LOCKOUT;
          lock_cnt <= LOCK_LOAD;
        end
        LOCKOUT: begin
          if (lock_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        RESULT: begin
          if (mode) leds  <= sel_tally;
          else      state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_controller.sv
// Testbench for vote_controller: directed votes with a response scoreboard.
// Instance 0 uses the default parameters; instance 1 uses a 2-bit tally and
// a short lockout to exercise saturation.
module tb_vote_controller;

  localparam int RESP_ACK = 1;
  localparam int RESP_ERR = 0;

  logic       clock;
  logic       reset;
  logic [3:0] vin  [2];
  logic       md   [2];
  logic [1:0] sel  [2];
  logic       ack  [2];
  logic       err  [2];
  logic       bsy  [2];
  logic [7:0] leds_a;
  logic [1:0] leds_b;

  int checks;
  int failures;

  // Expected responses (1 = ack, 0 = err), one queue per instance.
  int exp_q0[$];
  int exp_q1[$];

  vote_controller #(.NUM_CAND(4), .CNT_W(8), .LOCK_CYCLES(16)) dut_a (
    .clock    (clock),
    .reset    (reset),
    .vote_in  (vin[0]),
    .mode     (md[0]),
    .cand_sel (sel[0]),
    .vote_ack (ack[0]),
    .vote_err (err[0]),
    .busy     (bsy[0]),
    .leds     (leds_a)
  );

  vote_controller #(.NUM_CAND(4), .CNT_W(2), .LOCK_CYCLES(2)) dut_b (
    .clock    (clock),
    .reset    (reset),
    .vote_in  (vin[1]),
    .mode     (md[1]),
    .cand_sel (sel[1]),
    .vote_ack (ack[1]),
    .vote_err (err[1]),
    .busy     (bsy[1]),
    .leds     (leds_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle vote pulse; resp < 0 means no response is expected.
  task automatic vote(input int idx, input logic [3:0] v, input int resp);
    if (resp >= 0) begin
      if (idx == 0) exp_q0.push_back(resp);
      else          exp_q1.push_back(resp);
    end
    vin[idx] = v;
    tick();
    vin[idx] = 4'b0000;
  endtask

  task automatic wait_idle(input int idx);
    for (int i = 0; i < 60 && bsy[idx] === 1'b1; i++) tick();
    check($sformatf("idle_wait_%0d", idx), {31'd0, bsy[idx]}, 0);
  endtask

  // Monitor for instance 0: compare each ack/err pulse with the scoreboard.
  always @(negedge clock) begin
    if (ack[0] === 1'b1 || err[0] === 1'b1) begin
      check("a_ack_err_exclusive", {31'd0, ack[0] & err[0]}, 0);
      if (exp_q0.size() == 0) check("a_unexpected_resp", {30'd0, ack[0], err[0]}, 0);
      else                    check("a_resp_kind", {31'd0, ack[0]}, exp_q0.pop_front());
    end
  end

  // Monitor for instance 1.
  always @(negedge clock) begin
    if (ack[1] === 1'b1 || err[1] === 1'b1) begin
      check("b_ack_err_exclusive", {31'd0, ack[1] & err[1]}, 0);
      if (exp_q1.size() == 0) check("b_unexpected_resp", {30'd0, ack[1], err[1]}, 0);
      else                    check("b_resp_kind", {31'd0, ack[1]}, exp_q1.pop_front());
    end
  end

  initial begin
    int cnt;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vin[i] = 4'b0000;
      md[i]  = 1'b0;
      sel[i] = 2'd0;
    end

    // Reset state.
    repeat (3) tick();
    check("rst_ack",  {31'd0, ack[0]}, 0);
    check("rst_err",  {31'd0, err[0]}, 0);
    check("rst_busy", {31'd0, bsy[0]}, 0);
    check("rst_leds", {24'd0, leds_a}, 0);
    reset = 1'b1;
    tick();

    // Single vote: ack one clock later, busy for 1 + 16 clocks.
    vote(0, 4'b0001, RESP_ACK);
    check("ack_latency", {31'd0, ack[0]}, 1);
    cnt = 0;
    while (bsy[0] === 1'b1 && cnt < 60) begin
      cnt++;
      tick();
    end
    check("busy_len_vote", cnt, 17);

    // Two buttons together: err pulse, LOCKOUT only (16 busy clocks).
    vote(0, 4'b0101, RESP_ERR);
    check("multi_err", {31'd0, err[0]}, 1);
    cnt = 0;
    while (bsy[0] === 1'b1 && cnt < 60) begin
      cnt++;
      tick();
    end
    check("busy_len_multi", cnt, 16);

    // Second vote 5 clocks later falls in lockout and is ignored.
    vote(0, 4'b0010, RESP_ACK);
    repeat (4) tick();
    vote(0, 4'b0010, -1);
    wait_idle(0);

    // Reset during lockout discards everything, outputs drop immediately.
    vote(0, 4'b1000, RESP_ACK);
    repeat (3) tick();
    check("pre_rst_busy", {31'd0, bsy[0]}, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, bsy[0]}, 0);
    check("async_rst_ack",  {31'd0, ack[0]}, 0);
    check("async_rst_leds", {24'd0, leds_a}, 0);
    tick();
    reset = 1'b1;
    vote(0, 4'b0100, RESP_ACK);
    check("post_rst_ack", {31'd0, ack[0]}, 1);
    wait_idle(0);

    // Build tallies {2,0,1,4} (candidate 2 already has one vote).
    repeat (2) begin
      vote(0, 4'b0001, RESP_ACK);
      wait_idle(0);
    end
    repeat (4) begin
      vote(0, 4'b1000, RESP_ACK);
      wait_idle(0);
    end

    // Result mode display, one clock latency; votes ignored here.
    md[0]  = 1'b1;
    sel[0] = 2'd3;
    tick();
    check("leds_cand3", {24'd0, leds_a}, 4);
    check("result_not_busy", {31'd0, bsy[0]}, 0);
    sel[0] = 2'd1;
    vin[0] = 4'b0001;
    tick();
    vin[0] = 4'b0000;
    check("leds_cand1", {24'd0, leds_a}, 0);
    sel[0] = 2'd0;
    tick();
    check("leds_cand0", {24'd0, leds_a}, 2);
    sel[0] = 2'd2;
    tick();
    check("leds_cand2", {24'd0, leds_a}, 1);
    md[0] = 1'b0;
    tick();
    check("leds_voting", {24'd0, leds_a}, 0);

    // Mode raised during lockout only takes effect after return to IDLE.
    vote(0, 4'b0001, RESP_ACK);
    md[0]  = 1'b1;
    sel[0] = 2'd0;
    tick();
    check("mode_in_lockout_leds", {24'd0, leds_a}, 0);
    check("mode_in_lockout_busy", {31'd0, bsy[0]}, 1);
    wait_idle(0);
    tick();
    check("mode_after_lockout", {24'd0, leds_a}, 3);
    md[0] = 1'b0;
    tick();

    // 2-bit tally: five votes for candidate 3 -> 3 acks then 2 errs.
    sel[1] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      vote(1, 4'b1000, (i < 3) ? RESP_ACK : RESP_ERR);
      wait_idle(1);
    end
    md[1] = 1'b1;
    tick();
    check("sat_tally", {30'd0, leds_b}, 3);
    md[1] = 1'b0;
    tick();

    // Every expected response must have been observed.
    repeat (2) tick();
    check("a_queue_drained", exp_q0.size(), 0);
    check("b_queue_drained", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vote_controller.md
VOTE_CONTROLLER -- requirements
Module: vote_controller

Interface
REQ-001 SHALL have parameter NUM_CAND, default 4, meaning number of candidates (2..8).
REQ-002 SHALL have parameter CNT_W, default 8, meaning per-candidate tally width in bits.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16, meaning post-vote lockout length in clocks (>=1).
REQ-004 SHALL have port clock  input  1  meaning the single clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port vote_in  input  NUM_CAND  meaning one-cycle valid-vote pulses, one bit per candidate, from per-button debouncers.
REQ-007 SHALL have port mode  input  1  meaning 0 = voting, 1 = result display.
REQ-008 SHALL have port cand_sel  input  clog2(NUM_CAND)  meaning candidate whose tally is shown in result mode.
REQ-009 SHALL have port vote_ack  output  1  meaning one-cycle pulse when a vote is counted.
REQ-010 SHALL have port vote_err  output  1  meaning one-cycle pulse when a vote is rejected.
REQ-011 SHALL have port busy  output  1  meaning high while in ACCEPT or LOCKOUT.
REQ-012 SHALL have port leds  output  CNT_W  meaning registered tally display.

Function
REQ-013 SHALL implement FSM states IDLE, ACCEPT, LOCKOUT, RESULT.
REQ-014 IDLE: mode=1 -> RESULT; else exactly one vote_in bit set -> ACCEPT, latching that candidate index; else stay.
REQ-015 IDLE with more than one vote_in bit set in the same cycle SHALL count nothing, pulse vote_err next cycle, and enter LOCKOUT.
REQ-016 ACCEPT (one cycle): increment the latched candidate tally by 1 and pulse vote_ack, then enter LOCKOUT; counting latency is one clock after the vote_in pulse.
REQ-017 A tally at 2^CNT_W-1 SHALL saturate: no increment, vote_err pulses instead of vote_ack, LOCKOUT still entered.
REQ-018 LOCKOUT SHALL last exactly LOCK_CYCLES clocks, ignoring all vote_in bits, then return to IDLE.
REQ-019 mode SHALL be sampled only in IDLE and RESULT; a mode change during ACCEPT/LOCKOUT takes effect once back in IDLE.
REQ-020 RESULT: vote_in ignored; mode=0 -> IDLE.
REQ-021 In RESULT, leds SHALL equal tally[cand_sel] registered (one-clock latency); cand_sel >= NUM_CAND gives leds = 0.
REQ-022 Outside RESULT, leds SHALL be 0.
REQ-023 vote_ack and vote_err SHALL never be high in the same cycle.
REQ-024 Tallies SHALL change only in ACCEPT; no tally decrement or clear except reset.

Reset
REQ-025 reset low SHALL immediately force state IDLE, all tallies 0, lockout counter 0, vote_ack=0, vote_err=0, busy=0, leds=0.
REQ-026 reset asserted mid-ACCEPT or mid-LOCKOUT SHALL discard the in-flight vote; after release the first valid vote_in is accepted normally.
REQ-027 Release of reset SHALL be handled by synchronous deassertion at the integration level; the block requires no extra cycles after release.

Verification
REQ-028 mode=0, vote_in=0001 single pulse -> vote_ack at next edge, busy high 1+LOCK_CYCLES clocks, tally[0]=1.
REQ-029 vote_in=0101 same cycle -> vote_err pulse, no ack, all tallies unchanged, LOCKOUT entered.
REQ-030 vote_in=0010 pulse, then 0010 again 5 clocks later (LOCK_CYCLES=16) -> only one ack, tally[1]=1.
REQ-031 CNT_W=2: 5 votes for candidate 3 -> acks on first 3, vote_err on last 2, tally[3]=3.
REQ-032 After tallies {2,0,1,4}: mode=1, cand_sel=3 -> leds=4 one clock later; cand_sel=1 -> leds=0; mode=0 -> leds=0.
REQ-033 reset pulsed low during LOCKOUT -> all outputs 0 asynchronously, tallies 0, next single vote acknowledged with 1-clock latency.
